// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch (IF) and load/store (LS) ports.
// One transaction in flight, round-robin on contention, watchdog-forced error completion.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,

    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_wstrb,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    localparam logic        WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CNT_LAST = (TIMEOUT_CYCLES != 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic        OWN_IF   = 1'b0;
    localparam logic        OWN_LS   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_cmd_t;

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_owner;
    logic             r_last_owner;
    logic             r_mem_req;
    mem_cmd_t         r_cmd;
    mem_cmd_t         w_cmd_nxt;
    logic [CNT_W-1:0] r_cnt;

    logic             w_any_req;
    logic             w_pick_ls;
    logic             w_complete;
    logic             w_timeout;
    logic             w_resp;
    logic [31:0]      w_rdata;

    // On contention the port that did not own the previous transaction wins
    assign w_any_req  = if_req | ls_req;
    assign w_pick_ls  = ls_req & (~if_req | (r_last_owner == OWN_IF));
    assign w_complete = (r_state == ST_WAIT) & mem_rvalid;
    assign w_timeout  = WD_EN & (r_state != ST_IDLE) & (r_cnt == CNT_W'(CNT_LAST)) & ~w_complete;
    assign w_resp     = rst_n & (w_complete | w_timeout);
    assign w_rdata    = (w_complete & ~r_cmd.we) ? mem_rdata : 32'h0;

    // Command captured from the winning port; fetches are always reads
    always_comb begin
        w_cmd_nxt = '0;
        if (w_pick_ls) begin
            w_cmd_nxt.we    = ls_we;
            w_cmd_nxt.addr  = ls_addr;
            w_cmd_nxt.wdata = ls_wdata;
            w_cmd_nxt.wstrb = ls_we ? ls_wstrb : 4'b0000;
        end else begin
            w_cmd_nxt.addr  = if_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end else if (mem_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_complete || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latched command, ownership and watchdog counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner      <= OWN_IF;
            r_last_owner <= OWN_IF;
            r_mem_req    <= 1'b0;
            r_cmd        <= '0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner   <= w_pick_ls ? OWN_LS : OWN_IF;
                        r_cmd     <= w_cmd_nxt;
                        r_cnt     <= '0;
                        r_mem_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_timeout || mem_ready) begin
                        r_mem_req    <= 1'b0;
                        r_last_owner <= r_owner;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_timeout) begin
                        r_last_owner <= r_owner;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Grants and responses are combinational and suppressed while reset is held
    always_comb begin
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_err    = 1'b0;
        ls_err    = 1'b0;
        if_rdata  = 32'h0;
        ls_rdata  = 32'h0;
        if (rst_n && (r_state == ST_IDLE) && w_any_req) begin
            if (w_pick_ls) begin
                ls_gnt = 1'b1;
            end else begin
                if_gnt = 1'b1;
            end
        end
        if (w_resp) begin
            if (r_owner == OWN_LS) begin
                ls_rvalid = 1'b1;
                ls_err    = ~w_complete;
                ls_rdata  = w_rdata;
            end else begin
                if_rvalid = 1'b1;
                if_err    = ~w_complete;
                if_rdata  = w_rdata;
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_cmd.we;
    assign mem_addr  = r_cmd.addr;
    assign mem_wdata = r_cmd.wdata;
    assign mem_wstrb = r_cmd.wstrb;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [31:0] ls_addr, ls_wdata;
    logic [3:0]  ls_wstrb;
    logic        ls_gnt, ls_rvalid, ls_err;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    // Transaction-level model: one outstanding transaction, owner 1 = LS, 0 = IF
    logic        m_active, m_acc, m_owner, m_last, m_we;
    int          m_age;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        e_grant, e_win, e_done, e_to;

    task automatic eval_cycle();
        logic [31:0] exp_rdata;
        logic        resp;
        @(negedge clk);
        e_grant   = rst_n && !m_active && (if_req || ls_req);
        e_win     = (if_req && ls_req) ? !m_last : ls_req;
        e_done    = m_active && m_acc && mem_rvalid;
        e_to      = m_active && (m_age == int'(TO)) && !e_done;
        resp      = rst_n && (e_done || e_to);
        exp_rdata = (resp && e_done && !m_we) ? mem_rdata : 32'h0;
        check("if_gnt",    32'(if_gnt),    32'(e_grant && !e_win));
        check("ls_gnt",    32'(ls_gnt),    32'(e_grant && e_win));
        check("if_rvalid", 32'(if_rvalid), 32'(resp && !m_owner));
        check("ls_rvalid", 32'(ls_rvalid), 32'(resp && m_owner));
        check("if_err",    32'(if_err),    32'(resp && !m_owner && e_to));
        check("ls_err",    32'(ls_err),    32'(resp && m_owner && e_to));
        check("if_rdata",  if_rdata, (resp && !m_owner) ? exp_rdata : 32'h0);
        check("ls_rdata",  ls_rdata, (resp && m_owner) ? exp_rdata : 32'h0);
        check("busy",      32'(busy),      32'(m_active));
        check("mem_req",   32'(mem_req),   32'(m_active && !m_acc));
        if (m_active && !m_acc) begin
            check("mem_we",    32'(mem_we),    32'(m_we));
            check("mem_addr",  mem_addr,       m_addr);
            check("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
            if (m_we) check("mem_wdata", mem_wdata, m_wdata);
        end
    endtask

    task automatic edge_update();
        @(posedge clk);
        if (!rst_n) begin
            m_active = 1'b0;
            m_last   = 1'b0;
            m_owner  = 1'b0;
        end else if (!m_active) begin
            if (e_grant) begin
                m_active = 1'b1;
                m_acc    = 1'b0;
                m_age    = 1;
                m_owner  = e_win;
                m_we     = e_win && ls_we;
                m_addr   = e_win ? ls_addr : if_addr;
                m_wdata  = e_win ? ls_wdata : 32'h0;
                m_wstrb  = (e_win && ls_we) ? ls_wstrb : 4'b0000;
            end
        end else if (e_done || e_to) begin
            m_active = 1'b0;
            m_last   = m_owner;
        end else begin
            if (!m_acc && mem_ready) begin
                m_acc  = 1'b1;
                m_last = m_owner;
            end
            m_age++;
        end
        #1;
    endtask

    task automatic cyc();
        eval_cycle();
        edge_update();
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = $urandom;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = $urandom; ls_wdata = $urandom; ls_wstrb = 4'($urandom);
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
    endtask

    int owners[$];
    int p_rdy[4] = '{90, 50, 15, 100};
    int p_rv[4]  = '{70, 30, 8, 5};

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        edge_update();
        edge_update();
        eval_cycle();
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_addr",  mem_addr,       32'd0);
        check("rst_mem_wdata", mem_wdata,      32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        edge_update();
        rst_n = 1'b1;

        // single fetch, minimum latency
        if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1;
        eval_cycle(); check("fetch_gnt", 32'(if_gnt), 32'd1); edge_update();
        if_req = 1'b0; if_addr = $urandom;
        eval_cycle();
        check("fetch_mreq", 32'(mem_req), 32'd1);
        check("fetch_maddr", mem_addr, 32'h100);
        check("fetch_mwe", 32'(mem_we), 32'd0);
        edge_update();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
        eval_cycle();
        check("fetch_rvalid", 32'(if_rvalid), 32'd1);
        check("fetch_rdata", if_rdata, 32'h0050_0093);
        edge_update();
        idle_inputs(); cyc();

        // store held through two stall cycles; port inputs change after grant
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h2004; ls_wdata = 32'hDEAD_BEEF; ls_wstrb = 4'b0011;
        eval_cycle(); check("st_gnt", 32'(ls_gnt), 32'd1); edge_update();
        ls_req = 1'b0; ls_we = 1'b0; ls_wdata = $urandom; ls_wstrb = 4'hF; ls_addr = $urandom;
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            eval_cycle();
            check("st_mwe", 32'(mem_we), 32'd1);
            check("st_mwstrb", 32'(mem_wstrb), 32'h3);
            check("st_mwdata", mem_wdata, 32'hDEAD_BEEF);
            check("st_maddr", mem_addr, 32'h2004);
            edge_update();
        end
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        eval_cycle();
        check("st_rvalid", 32'(ls_rvalid), 32'd1);
        check("st_rdata", ls_rdata, 32'd0);
        check("st_err", 32'(ls_err), 32'd0);
        edge_update();
        idle_inputs(); cyc();

        // contention right after reset: LS, IF, LS, IF
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; mem_ready = 1'b1; mem_rvalid = 1'b1;
        for (int i = 0; i < 20 && owners.size() < 4; i++) begin
            eval_cycle();
            check("cont_excl", 32'(if_gnt & ls_gnt), 32'd0);
            if (if_gnt) owners.push_back(0);
            if (ls_gnt) owners.push_back(1);
            edge_update();
        end
        check("cont_count", 32'(owners.size()), 32'd4);
        foreach (owners[i]) check($sformatf("cont_order%0d", i), 32'(owners[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
        if_req = 1'b0; ls_req = 1'b0;
        repeat (3) cyc();
        idle_inputs(); cyc();

        // back-pressure: ready low five cycles, LS waits without a grant
        if_req = 1'b1; if_addr = 32'h300;
        eval_cycle(); check("bp_gnt", 32'(if_gnt), 32'd1); edge_update();
        if_req = 1'b0; ls_req = 1'b1; ls_addr = 32'h400;
        for (int i = 0; i < 6; i++) begin
            mem_ready = (i == 5);
            eval_cycle();
            check("bp_mreq", 32'(mem_req), 32'd1);
            check("bp_maddr", mem_addr, 32'h300);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_nognt", 32'(if_gnt | ls_gnt), 32'd0);
            edge_update();
        end
        ls_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = $urandom;
        eval_cycle();
        check("bp_rvalid", 32'(if_rvalid), 32'd1);
        check("bp_err", 32'(if_err), 32'd0);
        edge_update();
        idle_inputs(); cyc();

        // timeout on a load that is accepted but never answered
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h500;
        eval_cycle(); check("to_gnt", 32'(ls_gnt), 32'd1); edge_update();
        ls_req = 1'b0; mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        for (int c = 2; c < 8; c++) begin
            mem_rdata = $urandom | 32'h1;
            eval_cycle(); check("to_early", 32'(ls_rvalid), 32'd0); edge_update();
        end
        mem_rdata = $urandom | 32'h1;
        eval_cycle();
        check("to_rvalid", 32'(ls_rvalid), 32'd1);
        check("to_err", 32'(ls_err), 32'd1);
        check("to_rdata", ls_rdata, 32'd0);
        edge_update();
        mem_rvalid = 1'b1;
        eval_cycle();
        check("to_idle", 32'(busy), 32'd0);
        check("to_late", 32'(ls_rvalid | if_rvalid), 32'd0);
        check("to_mreq", 32'(mem_req), 32'd0);
        edge_update();
        idle_inputs(); cyc();

        // reset during WAIT of an LS load
        ls_req = 1'b1; ls_addr = 32'h600;
        cyc();
        ls_req = 1'b0; mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0; rst_n = 1'b0;
        eval_cycle(); check("rw_norv", 32'(ls_rvalid | if_rvalid), 32'd0); edge_update();
        rst_n = 1'b1; mem_rvalid = 1'b1;
        eval_cycle();
        check("rw_stray", 32'(ls_rvalid | if_rvalid), 32'd0);
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_mreq", 32'(mem_req), 32'd0);
        edge_update();
        mem_rvalid = 1'b0; if_req = 1'b1; ls_req = 1'b1;
        eval_cycle();
        check("rw_lsfirst", 32'(ls_gnt), 32'd1);
        check("rw_ifwait", 32'(if_gnt), 32'd0);
        edge_update();
        if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b1; mem_rvalid = 1'b1;
        repeat (3) cyc();
        idle_inputs(); cyc();

        // randomized traffic with varying memory responsiveness
        for (int seg = 0; seg < 4; seg++) begin
            for (int n = 0; n < 600; n++) begin
                rst_n      = ($urandom_range(0, 149) != 0);
                if_req     = 1'($urandom);
                if_addr    = $urandom;
                ls_req     = 1'($urandom);
                ls_we      = 1'($urandom);
                ls_addr    = $urandom;
                ls_wdata   = $urandom;
                ls_wstrb   = 4'($urandom);
                mem_ready  = ($urandom_range(0, 99) < p_rdy[seg]);
                mem_rvalid = ($urandom_range(0, 99) < p_rv[seg]);
                mem_rdata  = $urandom;
                cyc();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch port (IF) and the load/store port (LS) of the RV32I core.
- Picks one requester at a time and registers its request onto the memory interface.
- Waits for completion with a timeout watchdog, then routes the response back to the owner.
- Exactly one transaction outstanding; fair round-robin when both ports contend.

Parameters:
- TIMEOUT_CYCLES, 64, cycles in REQ+WAIT before a forced error completion; 0 disables the watchdog
- CNT_W, $clog2(TIMEOUT_CYCLES+1) (min 1), width of the watchdog counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active low
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch request captured this cycle
- if_rvalid  out  1  fetch response valid, one-cycle pulse
- if_rdata  out  32  fetch instruction word
- if_err  out  1  qualifies if_rvalid: timeout occurred
- ls_req  in  1  load/store request
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  32  data byte address
- ls_wdata  in  32  store data
- ls_wstrb  in  4  store byte enables
- ls_gnt  out  1  LS request captured this cycle
- ls_rvalid  out  1  LS response/completion pulse; stores also complete
- ls_rdata  out  32  load data (0 for stores and errors)
- ls_err  out  1  qualifies ls_rvalid: timeout occurred
- mem_req  out  1  registered request to memory
- mem_we  out  1  registered write enable
- mem_addr  out  32  registered address
- mem_wdata  out  32  registered write data
- mem_wstrb  out  4  registered byte enables; 4'b0000 on reads
- mem_ready  in  1  memory accepts request when high with mem_req
- mem_rvalid  in  1  memory response valid
- mem_rdata  in  32  memory read data
- busy  out  1  high in REQ or WAIT

Behaviour:
- FSM states: IDLE, REQ, WAIT. Reset (rst_n low at a clk edge):
  - state=IDLE, last_owner=IF, owner=IF, counter=0.
  - All mem_* outputs are 0.
  - All gnt/rvalid/err/rdata outputs are 0.
- IDLE arbitration (combinational):
  - Only one port requesting: that port wins.
  - Both requesting: the port not equal to last_owner wins, so LS wins first after reset.
  - Winner's gnt is high this cycle; the other gnt stays 0.
  - At the edge, latch owner, addr, we (0 for IF), wdata, and wstrb (0 for IF and for loads), then go to REQ.
- Requester may change or drop req after the gnt cycle; the latched copy is used.
- REQ: mem_req=1, with mem_* holding the latched values stable.
  - mem_ready=1 at an edge: go to WAIT, mem_req=0, last_owner=owner.
- WAIT:
  - mem_rvalid=1: owner's rvalid=1 in the same cycle (combinational).
  - For a load or fetch, rdata=mem_rdata; for a store, rdata=0. err=0.
  - Next state is IDLE.
- Minimum round trip:
  - req and gnt at cycle 0.
  - mem_req at cycle 1; ready at cycle 1.
  - rvalid at cycle 2 at the earliest.
  - New gnt possible at cycle 3.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - When counter==TIMEOUT_CYCLES-1 and no completion that cycle: owner's rvalid=1, err=1, rdata=0.
  - In that same case, mem_req drops next cycle and the FSM returns to IDLE; last_owner=owner.
  - If mem_rvalid and the timeout coincide in WAIT, the normal response wins (err=0).
- mem_rvalid outside WAIT (stray or late after timeout/reset): ignored, no requester output.
- Non-owner rvalid, rdata and err are 0 at all times.
- gnt is never asserted outside IDLE; requests arriving in REQ or WAIT wait for IDLE.
- Reset asserted mid-transaction: abort immediately to IDLE at that edge, with no response pulse.
- busy = (state != IDLE).

Test Plan:
- Reset, then a single fetch: if_req=1, if_addr=0x100, mem_ready=1 at once, mem_rvalid the next cycle with 0x00500093 -> if_gnt at cycle 0; mem_req/mem_addr=0x100/mem_we=0 at cycle 1; if_rvalid=1, if_rdata=0x00500093 at cycle 2.
- Store: ls_we=1, ls_addr=0x2004, ls_wdata=0xDEADBEEF, ls_wstrb=4'b0011 -> mem_we=1, mem_wstrb=0011, data stable until mem_ready; ls_rvalid=1, ls_rdata=0, ls_err=0.
- Contention: if_req and ls_req both held high for 4 transactions -> grant order LS, IF, LS, IF; if_gnt and ls_gnt never high together.
- Back-pressure: mem_ready held low 5 cycles -> mem_req and mem_addr stable for 6 cycles; busy=1 throughout; no gnt issued meanwhile.
- Timeout with TIMEOUT_CYCLES=8: memory never responds to a load -> ls_rvalid=1, ls_err=1, ls_rdata=0 at cycle 8 after REQ entry; state IDLE next; a late mem_rvalid produces no output.
- Reset mid-WAIT: rst_n low one cycle, then mem_rvalid=1 -> no rvalid on either port; busy=0; mem_req=0; the next request is granted to LS first.
